// File: rtl/alu_pkg.sv
// Shared opcode map and controller state encoding for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_ADD    = 0;
  localparam int unsigned OP_SUB    = 1;
  localparam int unsigned OP_AND    = 2;
  localparam int unsigned OP_OR     = 3;
  localparam int unsigned OP_NAND   = 4;
  localparam int unsigned OP_NOR    = 5;
  localparam int unsigned OP_XOR    = 6;
  localparam int unsigned OP_XNOR   = 7;
  localparam int unsigned OP_MUL    = 8;
  localparam int unsigned OP_DIV    = 9;
  localparam int unsigned OP_LSHIFT = 10;
  localparam int unsigned OP_RSHIFT = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_div.sv
// Unsigned restoring divider, one quotient bit per clock.
// The start cycle loads the operands and performs the first step, so
// done pulses one cycle after the WIDTH-th step.
module alu_iter_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_in;
  logic [WIDTH-1:0] quo_in;
  logic [WIDTH-1:0] div_in;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH:0]   trial;

  // One restoring step, on fresh operands at start or on the running state
  always_comb begin
    rem_in = start ? '0 : remainder;
    quo_in = start ? dividend : quotient;
    div_in = start ? divisor : div_q;
    trial  = {rem_in, quo_in[WIDTH-1]};
    quo_nx = quo_in << 1;
    rem_nx = trial[WIDTH-1:0];
    if (trial >= {1'b0, div_in}) begin
      rem_nx    = WIDTH'(trial - {1'b0, div_in});
      quo_nx[0] = 1'b1;
    end
  end

  // Iteration state; done is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder <= rem_nx;
        quotient  <= quo_nx;
        div_q     <= divisor;
        cnt_q     <= CW'(WIDTH - 1);
        busy      <= (WIDTH > 1);
        done      <= (WIDTH == 1);
      end else if (busy) begin
        remainder <= rem_nx;
        quotient  <= quo_nx;
        cnt_q     <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: single-cycle ops finish in one cycle, DIV runs
// the iterative divider. Result is held in DONE until out_ready.
// Optional macro ALU_SEQ_DIVZERO_TRAP_EN: DIV by zero completes immediately
// with an all-ones result and err set.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(NUM_OPS):0] op_select,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       result,
  output logic                     err
);

  localparam int unsigned OPW = $clog2(NUM_OPS) + 1;
  localparam int unsigned RW  = 2 * WIDTH;

  state_t           state_q;
  state_t           state_d;
  logic [RW-1:0]    result_d;
  logic             err_d;
  logic             div_start_c;
  logic             is_div_c;
  logic             go_div_c;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  // Single-cycle operations; shifts of RW or more fall out as zero
  function automatic logic [RW-1:0] alu_eval(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [OPW-1:0]   op);
    logic [RW-1:0]    zx;
    logic [RW-1:0]    zy;
    logic [WIDTH-1:0] t;
    zx = RW'(x);
    zy = RW'(y);
    t  = '0;
    alu_eval = '0;
    unique case (32'(op))
      OP_ADD:    alu_eval = zx + zy;
      OP_SUB:    alu_eval = zx - zy;
      OP_AND:    begin t = x & y;    alu_eval = RW'(t); end
      OP_OR:     begin t = x | y;    alu_eval = RW'(t); end
      OP_NAND:   begin t = ~(x & y); alu_eval = RW'(t); end
      OP_NOR:    begin t = ~(x | y); alu_eval = RW'(t); end
      OP_XOR:    begin t = x ^ y;    alu_eval = RW'(t); end
      OP_XNOR:   begin t = ~(x ^ y); alu_eval = RW'(t); end
      OP_MUL:    alu_eval = zx * zy;
      OP_LSHIFT: alu_eval = zx << y;
      OP_RSHIFT: alu_eval = zx >> y;
      default:   alu_eval = '0;
    endcase
  endfunction

  // Decide whether an accepted command needs the divider
  always_comb begin
    is_div_c = (32'(op_select) == OP_DIV);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    go_div_c = is_div_c && (b != '0);
`else
    go_div_c = is_div_c;
`endif
  end

  alu_iter_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start_c),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      result    <= result_d;
      err       <= err_d;
    end
  end

  // Next-state logic; DIV falls back to IDLE if the divider ever stalls
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = go_div_c ? ST_DIV : ST_DONE;
      ST_DIV: begin
        if (div_done)      state_d = ST_DONE;
        else if (!div_busy) state_d = ST_IDLE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next output values and divider launch
  always_comb begin
    div_start_c = 1'b0;
    result_d    = result;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    err_d       = err;
`else
    err_d       = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (go_div_c) begin
            div_start_c = 1'b1;
          end else begin
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
            if (is_div_c) begin
              result_d = '1;
              err_d    = 1'b1;
            end else begin
              result_d = alu_eval(a, b, op_select);
              err_d    = 1'b0;
            end
`else
            result_d = alu_eval(a, b, op_select);
`endif
          end
        end
      end
      ST_DIV: begin
        if (div_done) begin
          result_d = {div_rem, div_quo};
          err_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed corner cases, a mid-divide
// reset, then randomized commands checked against an arithmetic model.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  op_select = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_ctrl #(.WIDTH(32), .NUM_OPS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_select (op_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result, err and accept-to-out_valid latency in cycles
  function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] r, output logic e, output int lat);
    logic [63:0] zx;
    logic [63:0] zy;
    zx = {32'd0, x};
    zy = {32'd0, y};
    e = 1'b0;
    lat = 1;
    case (op)
      5'd0:  r = zx + zy;
      5'd1:  r = zx - zy;
      5'd2:  r = {32'd0, x & y};
      5'd3:  r = {32'd0, x | y};
      5'd4:  r = {32'd0, ~(x & y)};
      5'd5:  r = {32'd0, ~(x | y)};
      5'd6:  r = {32'd0, x ^ y};
      5'd7:  r = {32'd0, ~(x ^ y)};
      5'd8:  r = zx * zy;
      5'd9: begin
        if (y == 32'd0) begin
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
          r = '1;
          e = 1'b1;
`else
          r = {x, 32'hFFFF_FFFF};
          lat = 33;
`endif
        end else begin
          r = {x % y, x / y};
          lat = 33;
        end
      end
      5'd10: r = (y >= 32'd64) ? 64'd0 : (zx << y);
      5'd11: r = zx >> y;
      default: r = 64'd0;
    endcase
  endfunction

  // Issue one command, scramble inputs while busy, check latency/result, hold, handshake
  task automatic run_cmd(input string tag, input logic [4:0] op, input logic [31:0] x,
                         input logic [31:0] y, input int hold);
    logic [63:0] er;
    logic        ee;
    int          el;
    int          n;
    model(op, x, y, er, ee, el);
    check({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op_select = op; a = x; b = y; out_ready = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'($urandom); a = $urandom; b = $urandom; op_select = 5'($urandom);
    while (out_valid !== 1'b1 && n < 100) begin
      check({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = 1'($urandom); a = $urandom; b = $urandom; op_select = 5'($urandom);
    end
    check({tag, " latency"}, 64'(n), 64'(el));
    check({tag, " result"}, result, er);
    check({tag, " err"}, 64'(err), 64'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold result"}, result, er);
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check({tag, " post out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " post in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    run_cmd("add_carry", 5'd0, 32'hFFFF_FFFF, 32'd1, 0);
    check("add_carry const", result, 64'h1_0000_0000);
    run_cmd("div_100_7", 5'd9, 32'd100, 32'd7, 2);
    run_cmd("div_zero", 5'd9, 32'h1234_5678, 32'd0, 0);
    run_cmd("mul_max", 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_cmd("op15", 5'd15, 32'hDEAD_BEEF, 32'h0000_0003, 0);
    run_cmd("lshift_64", 5'd10, 32'd1, 32'd64, 0);
    run_cmd("lshift_63", 5'd10, 32'd1, 32'd63, 0);
    run_cmd("sub_neg", 5'd1, 32'd3, 32'd5, 1);
    run_cmd("nand", 5'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);

    // Reset in the middle of a divide
    in_valid = 1'b1; op_select = 5'd9; a = 32'hFFFF_0000; b = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd("add_after_rst", 5'd0, 32'd2, 32'd3, 0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 17));
      ra = $urandom;
      rb = $urandom;
      if (rop == 5'd10 || rop == 5'd11) rb = 32'($urandom_range(0, 70));
      if (rop == 5'd9 && $urandom_range(0, 7) == 0) rb = 32'd0;
      if (rop == 5'd9 && $urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 1000));
      run_cmd("rand", rop, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
